// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared FSM state encoding and default operand width for the Booth multiplier.
package multiplier_pkg;

    localparam int SIZE_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

    // Width of an iteration counter that must reach n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_datapath.sv
// booth_datapath: radix-2 Booth AC/Q/Q_1/M registers with add/subtract and arithmetic right shift.
module booth_datapath #(
    parameter int size = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [size-1:0]     a,
    input  logic [size-1:0]     b,
    output logic [2*size-1:0]   prod_next
);

    logic [size:0]   m_q, m_d, ac_q, ac_d, sum;
    logic [size-1:0] q_q, q_d;
    logic            q1_q, q1_d;

    always_comb begin
        sum = ({q_q[0], q1_q} == 2'b01) ? ac_q + m_q :
              ({q_q[0], q1_q} == 2'b10) ? ac_q - m_q : ac_q;
        m_d  = load ? {a[size-1], a} : m_q;
        ac_d = load ? '0 : step ? {sum[size], sum[size:1]} : ac_q;
        q_d  = load ? b : step ? {sum[0], q_q[size-1:1]} : q_q;
        q1_d = load ? 1'b0 : step ? q_q[0] : q1_q;
        // Low size bits of the shifted AC concatenated with the shifted Q.
        prod_next = {sum[size:1], sum[0], q_q[size-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q  <= '0;
            ac_q <= '0;
            q_q  <= '0;
            q1_q <= 1'b0;
        end else begin
            m_q  <= m_d;
            ac_q <= ac_d;
            q_q  <= q_d;
            q1_q <= q1_d;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential signed Booth multiplier, one iteration per clock,
// with a START/END_MULT handshake and a registered product.
module shift_add_multiplier
    import multiplier_pkg::*;
#(
    parameter int size = SIZE_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [size-1:0]     A,
    input  logic [size-1:0]     B,
    output logic [2*size-1:0]   S,
    output logic                END_MULT
);

    localparam int CW = cnt_width(size);

    mult_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*size-1:0] s_q, s_d, prod_next;
    logic              end_mult_q, end_mult_d;
    logic              load, step;

    booth_datapath #(.size(size)) u_dp (
        .clk       (CLK),
        .rst       (RESET),
        .load      (load),
        .step      (step),
        .a         (A),
        .b         (B),
        .prod_next (prod_next)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_d        = s_q;
        end_mult_d = end_mult_q;
        load       = 1'b0;
        step       = 1'b0;
        case (state_q)
            IDLE: begin
                end_mult_d = 1'b0;
                if (START) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(size - 1)) begin
                    s_d        = prod_next;
                    end_mult_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                end_mult_d = START;
                state_d    = START ? DONE : IDLE;
            end
            default: begin
                end_mult_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s_q        <= '0;
            end_mult_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            end_mult_q <= end_mult_d;
        end
    end

    assign S        = s_q;
    assign END_MULT = end_mult_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scoreboard bench for the Booth multiplier handshake, latency and products.
module tb_shift_add_multiplier;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [15:0] S;
    logic        END_MULT;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] sb[$];

    shift_add_multiplier #(.size(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .A        (A),
        .B        (B),
        .S        (S),
        .END_MULT (END_MULT)
    );

    always #5 CLK = ~CLK;

    // Request a multiply, scramble the operands after the sampling edge, and
    // return how many edges passed until END_MULT rose (20 means it never did).
    task automatic go(input logic signed [7:0] a, input logic signed [7:0] b,
                      input bit toggle, output int n);
        logic signed [15:0] p;
        p = a * b;
        @(negedge CLK);
        A = a;
        B = b;
        START = 1'b1;
        sb.push_back(p);
        @(posedge CLK);
        #1;
        A = 8'($urandom);
        B = 8'($urandom);
        n = 0;
        while (n < 20 && !END_MULT) begin
            START = (toggle && n < 6) ? 1'($urandom) : 1'b1;
            @(posedge CLK);
            #1;
            n++;
        end
        START = 1'b1;
    endtask

    task automatic drop_start();
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if (S !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_s got %h want 0000", S);
        end
        vectors++;
        if (END_MULT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_end got %b want 0", END_MULT);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_products();
        logic [7:0]  ta[8] = '{8'd45, -8'sd45, 8'd45, -8'sd45, 8'h80, 8'h80, 8'd127, 8'd0};
        logic [7:0]  tb_[8] = '{8'd96, 8'd96, -8'sd96, -8'sd96, 8'h80, 8'd127, 8'd127, -8'sd77};
        logic [15:0] te[8] = '{16'h10E0, 16'hEF20, 16'hEF20, 16'h10E0, 16'h4000, 16'hC080, 16'h3F01, 16'h0000};
        logic [15:0] exp;
        int n;
        for (int i = 0; i < 8; i++) begin
            go(ta[i], tb_[i], 1'b0, n);
            vectors++;
            if (n !== 8) begin
                miscompares++;
                $display("FAIL latency[%0d] got %0d want 8", i, n);
            end
            exp = sb.pop_front();
            vectors++;
            if (S !== exp) begin
                miscompares++;
                $display("FAIL product[%0d] got %h want %h", i, S, exp);
            end
            vectors++;
            if (S !== te[i]) begin
                miscompares++;
                $display("FAIL table[%0d] got %h want %h", i, S, te[i]);
            end
            drop_start();
        end
    endtask

    task automatic test_handshake();
        logic [15:0] exp;
        int n;
        go(8'd100, -8'sd7, 1'b0, n);
        exp = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            vectors++;
            if (END_MULT !== 1'b1 || S !== exp) begin
                miscompares++;
                $display("FAIL hold[%0d] got end=%b s=%h want end=1 s=%h", i, END_MULT, S, exp);
            end
        end
        drop_start();
        vectors++;
        if (END_MULT !== 1'b0 || S !== exp) begin
            miscompares++;
            $display("FAIL release got end=%b s=%h want end=0 s=%h", END_MULT, S, exp);
        end
        go(8'd3, -8'sd5, 1'b0, n);
        exp = sb.pop_front();
        vectors++;
        if (n !== 8 || S !== 16'hFFF1 || S !== exp) begin
            miscompares++;
            $display("FAIL restart got n=%0d s=%h want n=8 s=fff1", n, S);
        end
        drop_start();
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        int n;
        @(negedge CLK);
        A = 8'd45;
        B = 8'd96;
        START = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        A = 8'd12;
        B = -8'sd12;
        @(posedge CLK);
        #1;
        vectors++;
        if (S !== 16'h0 || END_MULT !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got end=%b s=%h want end=0 s=0000", END_MULT, S);
        end
        @(negedge CLK);
        RESET = 1'b0;
        sb.push_back(16'(-144));
        @(posedge CLK);
        #1;
        n = 0;
        while (n < 20 && !END_MULT) begin
            @(posedge CLK);
            #1;
            n++;
        end
        exp = sb.pop_front();
        vectors++;
        if (n !== 8 || S !== exp || S !== 16'hFF70) begin
            miscompares++;
            $display("FAIL after_reset got n=%0d s=%h want n=8 s=ff70", n, S);
        end
        drop_start();
    endtask

    task automatic test_random();
        logic signed [7:0] a, b;
        logic [15:0] exp;
        bit cov_a[5], cov_b[5], cov_q[4];
        int n, hit, r;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 7);
            a = r == 0 ? -8'sd128 : r == 1 ? 8'sd127 : r == 2 ? 8'sd0 : 8'($urandom);
            r = $urandom_range(0, 7);
            b = r == 0 ? -8'sd128 : r == 1 ? 8'sd127 : r == 2 ? 8'sd0 : 8'($urandom);
            cov_a[a == -128 ? 0 : a < 0 ? 1 : a == 0 ? 2 : a < 127 ? 3 : 4] = 1'b1;
            cov_b[b == -128 ? 0 : b < 0 ? 1 : b == 0 ? 2 : b < 127 ? 3 : 4] = 1'b1;
            cov_q[{a[7], b[7]}] = 1'b1;
            go(a, b, 1'b1, n);
            exp = sb.pop_front();
            vectors++;
            if (n !== 8 || S !== exp) begin
                miscompares++;
                $display("FAIL random %0d*%0d got n=%0d s=%h want n=8 s=%h", a, b, n, S, exp);
            end
            drop_start();
        end
        hit = 0;
        for (int i = 0; i < 5; i++) hit += int'(cov_a[i]) + int'(cov_b[i]);
        for (int i = 0; i < 4; i++) hit += int'(cov_q[i]);
        vectors++;
        if (hit * 100 < 14 * 90) begin
            miscompares++;
            $display("FAIL coverage got %0d bins want >=13 of 14", hit);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
